// File: rtl/spi_shift_engine_pkg.sv
// Shared types and constants for the SPI shift engine.
// Bit order on the wire is selected with the SPI_LSB_FIRST_EN macro.
package spi_shift_engine_pkg;

    localparam int W_CPU               = 32;
    localparam int SPI_CLK_DIV_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    // Bit counter width; a one-bit floor keeps tiny configurations legal.
    function automatic int bitcnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: div_cnt runs 0..CLK_DIV-1 while enabled
// and raises tick on the last count; clr restarts the count at zero.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W_DIV = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
    localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(CLK_DIV - 1);

    logic [W_DIV-1:0] div_cnt_q;
    logic [W_DIV-1:0] div_cnt_d;

    assign tick = en && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI mode-0 master: one parallel word in, one word out.
// Define SPI_LSB_FIRST_EN for LSB-first wire order (default MSB-first).
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int W_DATA  = W_CPU,
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int W_BC = bitcnt_width(W_DATA);
    localparam logic [W_BC-1:0] LAST_BIT = W_BC'(W_DATA - 1);

    spi_state_e        state_q, state_d;
    logic [W_DATA-1:0] tx_sr_q, tx_sr_d;
    logic [W_DATA-1:0] rx_sr_q, rx_sr_d;
    logic [W_DATA-1:0] rx_data_q, rx_data_d;
    logic [W_BC-1:0]   bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_valid_q, rx_valid_d;

    logic              tick;
    logic              accept;
    logic              first_bit;
    logic              tx_next_bit;
    logic [W_DATA-1:0] tx_shifted;
    logic [W_DATA-1:0] rx_shifted;

    assign accept = tx_valid && tx_ready_q;

`ifdef SPI_LSB_FIRST_EN
    assign first_bit   = tx_data[0];
    assign tx_next_bit = tx_sr_q[1];
    assign tx_shifted  = {1'b0, tx_sr_q[W_DATA-1:1]};
    assign rx_shifted  = {miso, rx_sr_q[W_DATA-1:1]};
`else
    assign first_bit   = tx_data[W_DATA-1];
    assign tx_next_bit = tx_sr_q[W_DATA-2];
    assign tx_shifted  = {tx_sr_q[W_DATA-2:0], 1'b0};
    assign rx_shifted  = {rx_sr_q[W_DATA-2:0], miso};
`endif

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk (clk),
        .rst (rst),
        .en  (state_q != ST_IDLE),
        .clr (accept),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LEAD;
            ST_LEAD:  if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = ST_TRAIL;
            ST_TRAIL: if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // In SHIFT, sclk_q low means this tick is a rising edge, high a falling one.
    always_comb begin
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_sr_d    = tx_data;
                    mosi_d     = first_bit;
                    cs_n_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    bit_cnt_d  = '0;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = rx_shifted;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sr_d = rx_shifted;
                    end else if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_sr_d   = tx_shifted;
                        mosi_d    = tx_next_bit;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: an 8-bit/div-2 instance with a modelled slave
// and a 32-bit/div-1 instance with MISO looped back to MOSI.
module tb_spi_shift_engine;

    localparam int W8  = 8;
    localparam int W32 = 32;

    logic clk;
    logic rst;

    logic [W8-1:0]  tx_data8;
    logic           tx_valid8;
    logic           tx_ready8;
    logic [W8-1:0]  rx_data8;
    logic           rx_valid8;
    logic           miso8;
    logic           sclk8;
    logic           mosi8;
    logic           cs_n8;

    logic [W32-1:0] tx_data32;
    logic           tx_valid32;
    logic           tx_ready32;
    logic [W32-1:0] rx_data32;
    logic           rx_valid32;
    logic           miso32;
    logic           sclk32;
    logic           mosi32;
    logic           cs_n32;

    int n_checks;
    int n_errors;

    logic [W8-1:0]  exp_q8[$];
    logic [W8-1:0]  mosi_q8[$];
    logic [W32-1:0] exp_q32[$];

    logic [W8-1:0] slave8;
    logic [W8-1:0] slave_cur8;
    logic [W8-1:0] cap8;
    logic          prev_cs8, prev_sclk8, prev_rxv8;
    int            cs_low8, gap8, last_gap8, rise8;

    logic prev_cs32, prev_rxv32;
    int   cs_low32;

    spi_shift_engine #(.W_DATA(W8), .CLK_DIV(2)) u8 (
        .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .miso(miso8), .sclk(sclk8), .mosi(mosi8), .cs_n(cs_n8)
    );

    spi_shift_engine #(.W_DATA(W32), .CLK_DIV(1)) u32 (
        .clk(clk), .rst(rst), .tx_data(tx_data32), .tx_valid(tx_valid32),
        .tx_ready(tx_ready32), .rx_data(rx_data32), .rx_valid(rx_valid32),
        .miso(miso32), .sclk(sclk32), .mosi(mosi32), .cs_n(cs_n32)
    );

    assign miso32 = mosi32;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word bit index carried by the k-th SCLK rising edge.
    function automatic int wire_idx(input int w, input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return w - 1 - k;
`endif
    endfunction

    function automatic logic wire_bit8(input logic [W8-1:0] word, input int k);
        return word[wire_idx(W8, k)];
    endfunction

    // monitor + scoreboard, 8-bit instance
    always @(negedge clk) begin
        if (rst) begin
            prev_cs8   = 1'b1;
            prev_sclk8 = 1'b0;
            prev_rxv8  = 1'b0;
            rise8      = 0;
            cs_low8    = 0;
            gap8       = 0;
        end else begin
            if (prev_cs8 && !cs_n8) begin
                last_gap8  = gap8;
                gap8       = 0;
                cs_low8    = 0;
                rise8      = 0;
                cap8       = '0;
                slave_cur8 = slave8;
                miso8      = wire_bit8(slave_cur8, 0);
            end
            if (!cs_n8) cs_low8++;
            else gap8++;
            if (!prev_sclk8 && sclk8) begin
                if (rise8 < W8) cap8[wire_idx(W8, rise8)] = mosi8;
                rise8++;
                if (rise8 < W8) miso8 = wire_bit8(slave_cur8, rise8);
            end
            if (!prev_cs8 && cs_n8) begin
                check("cs_low8", cs_low8, 34);
                check("rises8", rise8, W8);
                check("sclk_end8", sclk8, 0);
                if (mosi_q8.size() > 0) check("mosi_word8", cap8, mosi_q8.pop_front());
                else check("mosi_unexp8", mosi_q8.size(), 1);
            end
            if (rx_valid8) begin
                check("rxv_pair8", prev_rxv8, 0);
                check("ready_at_rxv8", tx_ready8, 1);
                if (exp_q8.size() > 0) check("rx_data8", rx_data8, exp_q8.pop_front());
                else check("rx_unexp8", exp_q8.size(), 1);
            end
            prev_cs8   = cs_n8;
            prev_sclk8 = sclk8;
            prev_rxv8  = rx_valid8;
        end
    end

    // monitor + scoreboard, 32-bit loopback instance
    always @(negedge clk) begin
        if (rst) begin
            prev_cs32  = 1'b1;
            prev_rxv32 = 1'b0;
            cs_low32   = 0;
        end else begin
            if (prev_cs32 && !cs_n32) cs_low32 = 0;
            if (!cs_n32) cs_low32++;
            if (!prev_cs32 && cs_n32) check("cs_low32", cs_low32, 65);
            if (rx_valid32) begin
                check("rxv_pair32", prev_rxv32, 0);
                if (exp_q32.size() > 0) check("rx_data32", rx_data32, exp_q32.pop_front());
                else check("rx_unexp32", exp_q32.size(), 1);
            end
            prev_cs32  = cs_n32;
            prev_rxv32 = rx_valid32;
        end
    end

    // driver tasks; called at a negedge
    task automatic wait_ready8();
        int i;
        for (i = 0; i < 400; i++) begin
            if (tx_ready8) break;
            @(negedge clk);
        end
        if (i == 400) check("ready_timeout8", tx_ready8, 1);
    endtask

    task automatic send8(input logic [W8-1:0] d, input logic [W8-1:0] s);
        wait_ready8();
        slave8    = s;
        tx_data8  = d;
        tx_valid8 = 1'b1;
        exp_q8.push_back(s);
        mosi_q8.push_back(d);
        @(negedge clk);
        tx_valid8 = 1'b0;
    endtask

    task automatic send32(input logic [W32-1:0] d);
        int i;
        for (i = 0; i < 400; i++) begin
            if (tx_ready32) break;
            @(negedge clk);
        end
        if (i == 400) check("ready_timeout32", tx_ready32, 1);
        tx_data32  = d;
        tx_valid32 = 1'b1;
        exp_q32.push_back(d);
        @(negedge clk);
        tx_valid32 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, tx_ready8, 1);
        check({tag, "_rxdata"}, rx_data8, 0);
        check({tag, "_rxv"}, rx_valid8, 0);
        check({tag, "_sclk"}, sclk8, 0);
        check({tag, "_mosi"}, mosi8, 0);
        check({tag, "_csn"}, cs_n8, 1);
        check({tag, "_csn32"}, cs_n32, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        last_gap8  = -1;
        rst        = 1'b1;
        tx_data8   = '0;
        tx_valid8  = 1'b0;
        tx_data32  = '0;
        tx_valid32 = 1'b0;
        miso8      = 1'b0;
        slave8     = '0;

        // asynchronous reset is visible before any clock edge
        #3;
        check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", tx_ready8, 1);
        check("post_rst_csn", cs_n8, 1);

        // single transfer, modelled slave
        send8(8'hA5, 8'h3C);
        send8(8'h01, 8'h01);

        // back-to-back with tx_valid held through the busy period
        wait_ready8();
        slave8    = 8'h96;
        tx_data8  = 8'hFF;
        tx_valid8 = 1'b1;
        exp_q8.push_back(8'h96);
        mosi_q8.push_back(8'hFF);
        @(negedge clk);
        wait_ready8();
        check("b2b_rxv_with_ready", rx_valid8, 1);
        slave8   = 8'h69;
        tx_data8 = 8'h00;
        exp_q8.push_back(8'h69);
        mosi_q8.push_back(8'h00);
        @(negedge clk);
        tx_valid8 = 1'b0;
        @(negedge clk);
        check("b2b_gap", last_gap8, 1);

        // reset at the 4th rising SCLK edge aborts without rx_valid
        send8(8'h81, 8'h42);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (rise8 >= 4) break;
        end
        check("abort_reached_rise4", rise8, 4);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q8.delete();
        mosi_q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send8(8'h81, 8'hC3);

        // 32-bit loopback, concurrent with random 8-bit traffic
        send32(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        send32($urandom_range(0, 32'h7FFF_FFFF));

        for (int i = 0; i < 500; i++) begin
            if (exp_q8.size() == 0 && exp_q32.size() == 0) break;
            @(negedge clk);
        end
        check("drain8", exp_q8.size(), 0);
        check("drain32", exp_q32.size(), 0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
